tc_frame_encode: RTL
====================

TC_FRAME_ENCODE -- requirements
Module: tc_frame_encode

Interface
REQ-001 Parameter BLOCK_BYTES, default 7: bytes per code block; each block is 56 serial bits.
REQ-002 Parameter GAP_CYCLES, default 8: idle cycles with En_DataO low between blocks.
REQ-003 Parameter MAX_BLOCKS, default 4: maximum blocks per packet.
REQ-004 Parameter TYPE_IP, default 4'b0010: packet type field. Parameter VERSION, default 4'b0000: version field.
REQ-005 Ports; one clock; reset is asynchronous and active-high:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle packet start request.
- SCID  in  16  spacecraft ID; sampled on accepted Start.
- ByteI  in  8  payload byte.
- ByteValid  in  1  ByteI valid.
- ByteLast  in  1  ByteI is the final payload byte.
- ByteReady  out  1  encoder accepts ByteI this cycle.
- DataO  out  1  serial bit, MSB first.
- En_DataO  out  1  high for every block bit.
- IP_END_O  out  1  one-cycle end-of-packet pulse.
- Busy  out  1  high when not IDLE.
- Err_O  out  1  one-cycle truncation pulse.

Function
REQ-006 FSM states: IDLE, LOAD, SEND, GAP, END.
REQ-007 IDLE: Start=1 latches SCID, clears the block counter, preloads buffer bytes 0..2 with {SCID, TYPE_IP, VERSION}, and enters LOAD next cycle; Start outside IDLE is ignored.
REQ-008 LOAD: ByteReady=1.
- A byte transfers only when ByteValid and ByteReady are both high, filling the next free buffer byte.
- LOAD exits to SEND when the buffer holds BLOCK_BYTES bytes, or in the cycle after ByteLast transfers.
- Unfilled bytes pad with 8'h55.
REQ-009 SEND: DataO shifts out the buffer MSB first, one bit per cycle, for exactly 8*BLOCK_BYTES cycles.
- En_DataO=1 throughout SEND.
- The first bit is registered and appears on the cycle after the LOAD exit.
- The block counter increments at SEND entry.
REQ-010 GAP: En_DataO=0 and DataO=0 for exactly GAP_CYCLES cycles, then:
- END if ByteLast has transferred, or if the block counter equals MAX_BLOCKS;
- otherwise LOAD, with an empty buffer and no header.
REQ-011 END: IP_END_O=1 for one cycle, then IDLE.
REQ-012 Truncation: if MAX_BLOCKS blocks are sent without ByteLast, Err_O pulses in the same cycle as IP_END_O; the packet is not continued.
REQ-013 ByteReady=0 in every state except LOAD; no bytes are accepted in SEND, GAP, END or IDLE.
REQ-014 ByteLast with ByteValid low is ignored.
REQ-015 A ByteLast that fills the buffer exactly produces no pad bytes and no extra block.
REQ-016 A header-only packet (ByteLast on the first payload byte of block 1) still sends one full padded block.
REQ-017 The block counter is 3 bits wide minimum and saturates at MAX_BLOCKS.

Reset
REQ-018 Rst=1 asynchronously forces, regardless of state (including mid-SEND):
- IDLE;
- DataO, En_DataO, IP_END_O, ByteReady, Busy, Err_O = 0;
- buffer, bit counter, block counter and latched SCID cleared.
REQ-019 After Rst deasserts, the first accepted Start is the earliest activity; no partial block resumes.

Configuration
REQ-020 Macro TC_ENC_RANDOMIZE_EN.
- Defined: payload and pad bits (never the 24 header bits) are XORed with a PN sequence, polynomial x^8+x^7+x^5+x^3+1, seeded 8'hFF at each packet start, advancing one step per payload bit.
- Undefined: bits are sent unmodified and no PN logic is instantiated.

Structure
REQ-021 A shared package tc_pkg holds the FSM state encoding, the pad constant 8'h55, the TYPE_IP/VERSION defaults, the header width 24, and the PN polynomial/seed.
REQ-022 One sub-module, tc_pn_gen (8-bit LFSR with enable and synchronous load), is instantiated only under TC_ENC_RANDOMIZE_EN.

Verification
REQ-023 Bench must cover these scenarios:
- Start with SCID=16'h0100, then 4 bytes 11,22,33,44 with ByteLast on 44 -> one block, bits 01 00 20 11 22 33 44, 56 En cycles, 8-cycle gap, IP_END_O pulse, Err_O=0.
- 11 payload bytes with ByteValid held high -> two blocks; block 2 = bytes 5..11, no header; IP_END_O once.
- 40 bytes with no ByteLast -> 4 blocks, then IP_END_O and Err_O coincident; ByteReady=0 afterward.
- Rst asserted at bit 20 of block 1 -> same-cycle En_DataO=0 and Busy=0; a new Start produces a fresh header.
- ByteValid toggling 1/0 each cycle in LOAD -> block content identical to the continuous case, start delayed by the stall cycles.
- With TC_ENC_RANDOMIZE_EN defined: the 24 header bits are unchanged and payload bit 0 = data XOR 1 (seed MSB); undefined: payload sent in clear.

Source files
------------

// File: rtl/tc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tc_pkg
// Purpose  : Shared constants for the TC frame encoder: FSM state encoding,
//            pad byte, header field defaults, header width and PN setup.
// Revision : 1.0 - initial release
// ============================================================================
package tc_pkg;

    // FSM state encoding
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_LOAD = 3'd1;
    localparam logic [2:0] c_ST_SEND = 3'd2;
    localparam logic [2:0] c_ST_GAP  = 3'd3;
    localparam logic [2:0] c_ST_END  = 3'd4;

    // Filler for block bytes that carry no payload
    localparam logic [7:0] c_PAD_BYTE = 8'h55;

    // Header field defaults
    localparam logic [3:0] c_TYPE_IP_DEF = 4'b0010;
    localparam logic [3:0] c_VERSION_DEF = 4'b0000;

    // Header = SCID(16) + TYPE(4) + VERSION(4)
    localparam int c_HDR_BITS = 24;

    // PN generator x^8+x^7+x^5+x^3+1: feedback taps on state bits 7,6,4,2
    localparam logic [7:0] c_PN_TAPS = 8'hD4;
    localparam logic [7:0] c_PN_SEED = 8'hFF;

endpackage : tc_pkg
`default_nettype wire

// File: rtl/tc_pn_gen.sv
`default_nettype none
// ============================================================================
// Module   : tc_pn_gen
// Purpose  : 8-bit Fibonacci LFSR producing the randomizer PN bit stream.
//            load_i reseeds synchronously and has priority over en_i.
// Revision : 1.0 - initial release
// ============================================================================
module tc_pn_gen
    import tc_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic load_i,
    output logic pn_o
);

    logic [7:0] lfsr_q;

    // LFSR state: reseed on load, advance one step per enabled cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= c_PN_SEED;
        end else if (load_i) begin
            lfsr_q <= c_PN_SEED;
        end else if (en_i) begin
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & c_PN_TAPS)};
        end
    end

    assign pn_o = lfsr_q[7];

endmodule : tc_pn_gen
`default_nettype wire

// File: rtl/tc_frame_encode.sv
`default_nettype none
// ============================================================================
// Module   : tc_frame_encode
// Purpose  : Packs a byte stream into fixed-size code blocks (first block of
//            a packet carries a 24-bit SCID/type/version header), shifts each
//            block out serially MSB first, separates blocks by an idle gap
//            and flags end of packet / truncation.
//            Optional macro TC_ENC_RANDOMIZE_EN XORs payload and pad bits
//            with a PN sequence (header bits stay in clear).
// Revision : 1.0 - initial release
// ============================================================================
module tc_frame_encode
    import tc_pkg::*;
#(
    parameter int         BLOCK_BYTES = 7,
    parameter int         GAP_CYCLES  = 8,
    parameter int         MAX_BLOCKS  = 4,
    parameter logic [3:0] TYPE_IP     = c_TYPE_IP_DEF,
    parameter logic [3:0] VERSION     = c_VERSION_DEF
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [15:0] SCID,
    input  logic [7:0]  ByteI,
    input  logic        ByteValid,
    input  logic        ByteLast,
    output logic        ByteReady,
    output logic        DataO,
    output logic        En_DataO,
    output logic        IP_END_O,
    output logic        Busy,
    output logic        Err_O
);

    localparam int c_BLK_BITS  = 8 * BLOCK_BYTES;
    localparam int c_CNT_MAX   = (c_BLK_BITS > GAP_CYCLES) ? c_BLK_BITS : GAP_CYCLES;
    localparam int c_CNT_W     = $clog2(c_CNT_MAX + 1);
    localparam int c_FILL_W    = $clog2(BLOCK_BYTES + 1);
    localparam int c_BLKC_RAW  = $clog2(MAX_BLOCKS + 1);
    localparam int c_BLKC_W    = (c_BLKC_RAW > 3) ? c_BLKC_RAW : 3;
    localparam int c_PAD_BYTES = BLOCK_BYTES - 3;

    // The SCID is latched straight into the header bytes of the buffer.
    logic [2:0]            state_q,  state_d;
    logic [c_BLK_BITS-1:0] buf_q,    buf_d;
    logic [c_FILL_W-1:0]   fill_q,   fill_d;
    logic [c_CNT_W-1:0]    cnt_q,    cnt_d;
    logic [c_BLKC_W-1:0]   blk_q,    blk_d;
    logic                  last_q,   last_d;
    logic                  w_scramble;

    // State and datapath registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= c_ST_IDLE;
            buf_q   <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            blk_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            last_q  <= last_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        last_d  = last_q;
        case (state_q)
            c_ST_IDLE: begin
                if (Start) begin
                    buf_d   = {SCID, TYPE_IP, VERSION, {c_PAD_BYTES{c_PAD_BYTE}}};
                    fill_d  = c_FILL_W'(3);
                    cnt_d   = '0;
                    blk_d   = '0;
                    last_d  = 1'b0;
                    state_d = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                if (ByteValid) begin
                    for (int i = 0; i < BLOCK_BYTES; i++) begin
                        if (fill_q == c_FILL_W'(i)) begin
                            buf_d[c_BLK_BITS-1-8*i -: 8] = ByteI;
                        end
                    end
                    fill_d = fill_q + c_FILL_W'(1);
                    if (ByteLast) begin
                        last_d = 1'b1;
                    end
                    if (ByteLast || (fill_q == c_FILL_W'(BLOCK_BYTES - 1))) begin
                        state_d = c_ST_SEND;
                        cnt_d   = '0;
                        if (blk_q != c_BLKC_W'(MAX_BLOCKS)) begin
                            blk_d = blk_q + c_BLKC_W'(1);
                        end
                    end
                end
            end
            c_ST_SEND: begin
                buf_d = {buf_q[c_BLK_BITS-2:0], 1'b0};
                cnt_d = cnt_q + c_CNT_W'(1);
                if (cnt_q == c_CNT_W'(c_BLK_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = c_ST_GAP;
                end
            end
            c_ST_GAP: begin
                cnt_d = cnt_q + c_CNT_W'(1);
                if (cnt_q == c_CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (last_q || (blk_q == c_BLKC_W'(MAX_BLOCKS))) begin
                        state_d = c_ST_END;
                    end else begin
                        buf_d   = {BLOCK_BYTES{c_PAD_BYTE}};
                        fill_d  = '0;
                        state_d = c_ST_LOAD;
                    end
                end
            end
            c_ST_END: begin
                state_d = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

`ifdef TC_ENC_RANDOMIZE_EN
    logic w_payload_bit;
    logic w_pn_load;
    logic w_pn_bit;

    // Header bits are the first 24 bits of block 1; everything else is scrambled
    assign w_payload_bit = (state_q == c_ST_SEND) &&
                           !((blk_q == c_BLKC_W'(1)) && (cnt_q < c_CNT_W'(c_HDR_BITS)));
    assign w_pn_load     = (state_q == c_ST_IDLE) && Start;

    tc_pn_gen u_pn_gen (
        .clk_i  (Clk),
        .rst_i  (Rst),
        .en_i   (w_payload_bit),
        .load_i (w_pn_load),
        .pn_o   (w_pn_bit)
    );

    assign w_scramble = w_payload_bit & w_pn_bit;
`else
    assign w_scramble = 1'b0;
`endif

    // Output decode from registered state
    always_comb begin
        ByteReady = (state_q == c_ST_LOAD);
        En_DataO  = (state_q == c_ST_SEND);
        DataO     = (state_q == c_ST_SEND) ? (buf_q[c_BLK_BITS-1] ^ w_scramble) : 1'b0;
        IP_END_O  = (state_q == c_ST_END);
        Err_O     = (state_q == c_ST_END) && !last_q;
        Busy      = (state_q != c_ST_IDLE);
    end

endmodule : tc_frame_encode
`default_nettype wire
